lsu_exec_unit: RTL and testbench
================================

// Module: lsu_exec_unit
// PURPOSE
//  Load/store execution stage fed by the LSU issue queue; accepts one issued memory uop at a time.
//  Computes the effective address (v1+imm), writes stores into their pre-allocated store-buffer entry,
//  and runs loads to the D-cache port; results go to the CDB/ROB writeback port.
//  fu_ready_o drives the issue queue's fu_ready_i, so the issue queue never issues while this unit is busy.
// PARAMETERS
//  DATA_W  32  data/address width
//  TAG_W   6   ROB tag width
//  SB_W    4   store-buffer index width
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  flush_i        in   1       pipeline flush (kill in-flight op)
//  lsu_en         in   1       issue valid
//  lsu_uop        in   uop_t   uses is_load, is_store, imm, mem_size[1:0] (0=B,1=H,2=W), mem_unsigned
//  lsu_v1         in   DATA_W  base register value
//  lsu_v2         in   DATA_W  store data
//  lsu_dst        in   TAG_W   ROB tag
//  lsu_sb_id      in   SB_W    store-buffer entry for stores
//  fu_ready_o     out  1       unit can accept an op this cycle
//  sb_wr_valid_o  out  1       store-buffer entry write strobe
//  sb_wr_id_o     out  SB_W    entry index
//  sb_wr_addr_o   out  DATA_W  word-aligned address
//  sb_wr_data_o   out  DATA_W  lane-shifted store data
//  sb_wr_mask_o   out  4       byte enables
//  dc_req_valid_o out  1       load request to D-cache
//  dc_req_ready_i in   1       D-cache accepts request
//  dc_req_addr_o  out  DATA_W  word-aligned load address
//  dc_rsp_valid_i in   1       load data return (exactly one per accepted request)
//  dc_rsp_data_i  in   DATA_W  returned word
//  wb_valid_o     out  1       writeback to CDB/ROB
//  wb_ready_i     in   1       CDB arbiter grant
//  wb_tag_o       out  TAG_W   ROB tag
//  wb_data_o      out  DATA_W  load result (0 for stores)
//  wb_exc_o       out  1       misaligned-access exception
// BEHAVIOUR
//  - FSM states: IDLE, LD_REQ, LD_WAIT, WB, DRAIN. Reset -> IDLE; all outputs 0 except fu_ready_o=1.
//  - fu_ready_o = (state==IDLE) & ~flush_i. Accept = lsu_en & fu_ready_o; latch uop, tag, addr=v1+imm (mod 2^DATA_W).
//  - Store on accept: same cycle combinational sb_wr_valid_o=1 with id/addr/data/mask; next state WB (wb_data_o=0).
//    Mask: B -> 1<<addr[1:0]; H -> 3<<addr[1:0]; W -> 4'hF. Data replicated/shifted to byte lane addr[1:0].
//  - Load on accept: -> LD_REQ. LD_REQ holds dc_req_valid_o=1 with stable addr until dc_req_ready_i; -> LD_WAIT.
//  - LD_WAIT: on dc_rsp_valid_i extract byte/half at addr[1:0], sign- or zero-extend per mem_unsigned, register it; -> WB.
//  - WB: wb_valid_o=1, outputs stable until wb_ready_i; then -> IDLE (fu_ready_o high next cycle).
//  - Latency (all handshakes immediate): store accept->wb_valid 1 cycle; load accept->wb_valid 3 cycles.
//  - flush_i: IDLE/LD_REQ/WB -> IDLE next cycle, no writeback; a not-yet-accepted request is withdrawn.
//    LD_WAIT -> DRAIN; DRAIN discards the pending dc_rsp_valid_i and returns to IDLE; fu_ready_o=0 in DRAIN.
//    flush_i in the accept cycle: op dropped, sb_wr_valid_o forced 0.
//  - dc_rsp_valid_i arriving in the same cycle flush_i is asserted during LD_WAIT: response consumed, -> IDLE (not DRAIN).
//  - rst asserted mid-operation: immediate return to IDLE, outputs to reset values, pending response ignored.
//  - uop with neither is_load nor is_store: treated as store with mask 0 (writeback only, no sb write).
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> no sb write / no D-cache request;
//    -> WB directly with wb_exc_o=1, wb_data_o=0.
//  Not defined: address silently aligned down to the access size; wb_exc_o tied 0.
// TESTING
//  LW v1=0x1000 imm=4, dc returns 0xDEADBEEF -> dc_req_addr_o=0x1004, wb_data_o=0xDEADBEEF, wb_valid 3 cycles after accept.
//  LB v1=0x2003 imm=0, rsp 0x80FF_FF00 signed -> wb_data_o=0xFFFFFF80; LBU -> 0x00000080.
//  SH v1=0x3000 imm=2 v2=0x1234ABCD sb_id=5 -> sb_wr_id_o=5, mask=4'b1100, data[31:16]=0xABCD, wb_data_o=0.
//  Flush in LD_WAIT, rsp 2 cycles later -> no wb_valid_o, fu_ready_o=0 until rsp, then 1 next cycle.
//  wb_ready_i low 3 cycles in WB -> wb_valid_o/tag/data held stable; new lsu_en ignored (fu_ready_o=0).
//  LSU_MISALIGN_TRAP_EN: LW addr 0x1002 -> wb_exc_o=1, no dc_req_valid_o; without macro -> dc_req_addr_o=0x1000.

Source files
------------

// File: rtl/lsu_exec_unit.sv
// Load/store execution stage: effective address, store-buffer write, D-cache load, CDB writeback.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/W accesses raise wb_exc_o).
package lsu_pkg;
    typedef struct packed {
        logic        is_load;
        logic        is_store;
        logic [31:0] imm;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
    } uop_t;
endpackage

module lsu_exec_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int SB_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              lsu_en,
    input  uop_t              lsu_uop,
    input  logic [DATA_W-1:0] lsu_v1,
    input  logic [DATA_W-1:0] lsu_v2,
    input  logic [TAG_W-1:0]  lsu_dst,
    input  logic [SB_W-1:0]   lsu_sb_id,
    output logic              fu_ready_o,
    output logic              sb_wr_valid_o,
    output logic [SB_W-1:0]   sb_wr_id_o,
    output logic [DATA_W-1:0] sb_wr_addr_o,
    output logic [DATA_W-1:0] sb_wr_data_o,
    output logic [3:0]        sb_wr_mask_o,
    output logic              dc_req_valid_o,
    input  logic              dc_req_ready_i,
    output logic [DATA_W-1:0] dc_req_addr_o,
    input  logic              dc_rsp_valid_i,
    input  logic [DATA_W-1:0] dc_rsp_data_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_exc_o
);

    typedef enum logic [2:0] {IDLE, LD_REQ, LD_WAIT, WB, DRAIN} state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   ea;
    logic                is_h, is_w, mis, trap, accept, is_ld, is_st;
    logic [1:0]          lo;
    logic [DATA_W-1:2]   waddr_q;
    logic [1:0]          lo_q, size_q;
    logic                uns_q, exc_q;
    logic [TAG_W-1:0]    tag_q;
    logic [DATA_W-1:0]   data_q, ld_val;
    logic [7:0]          rsp_b;
    logic [15:0]         rsp_h;

    // Address generation, alignment and misalignment detection for the issuing uop
    always_comb begin
        ea    = lsu_v1 + DATA_W'(lsu_uop.imm);
        is_h  = (lsu_uop.mem_size == 2'd1);
        is_w  = lsu_uop.mem_size[1];
        is_ld = lsu_uop.is_load;
        is_st = lsu_uop.is_store & ~lsu_uop.is_load;
        mis   = (is_h & ea[0]) | (is_w & (ea[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        trap  = mis & (is_ld | is_st);
        lo    = ea[1:0];
`else
        trap  = 1'b0;
        lo    = is_w ? 2'b00 : (is_h ? {ea[1], 1'b0} : ea[1:0]);
`endif
    end

    // Lane extraction and sign/zero extension of the returned load word
    always_comb begin
        rsp_b = dc_rsp_data_i[{lo_q, 3'b000} +: 8];
        rsp_h = dc_rsp_data_i[{lo_q[1], 4'b0000} +: 16];
        if (size_q[1])
            ld_val = dc_rsp_data_i;
        else if (size_q == 2'd1)
            ld_val = {{(DATA_W-16){~uns_q & rsp_h[15]}}, rsp_h};
        else
            ld_val = {{(DATA_W-8){~uns_q & rsp_b[7]}}, rsp_b};
    end

    // Next-state logic and all port outputs
    always_comb begin
        state_nx       = state;
        fu_ready_o     = (state == IDLE) & ~flush_i;
        accept         = lsu_en & fu_ready_o;
        sb_wr_valid_o  = accept & is_st & ~trap;
        sb_wr_id_o     = '0;
        sb_wr_addr_o   = '0;
        sb_wr_data_o   = '0;
        sb_wr_mask_o   = '0;
        dc_req_valid_o = (state == LD_REQ) & ~flush_i;
        dc_req_addr_o  = '0;
        wb_valid_o     = (state == WB) & ~flush_i;
        wb_tag_o       = '0;
        wb_data_o      = '0;
        wb_exc_o       = 1'b0;
        if (sb_wr_valid_o) begin
            sb_wr_id_o   = lsu_sb_id;
            sb_wr_addr_o = {ea[DATA_W-1:2], 2'b00};
            if (is_w) begin
                sb_wr_mask_o = 4'hF;
                sb_wr_data_o = lsu_v2;
            end else if (is_h) begin
                sb_wr_mask_o = 4'b0011 << lo;
                sb_wr_data_o = {(DATA_W/16){lsu_v2[15:0]}};
            end else begin
                sb_wr_mask_o = 4'b0001 << lo;
                sb_wr_data_o = {(DATA_W/8){lsu_v2[7:0]}};
            end
        end
        if (state == LD_REQ)
            dc_req_addr_o = {waddr_q, 2'b00};
        if (state == WB) begin
            wb_tag_o  = tag_q;
            wb_data_o = data_q;
            wb_exc_o  = exc_q;
        end
        unique case (state)
            IDLE:
                if (accept)
                    state_nx = (is_ld & ~trap) ? LD_REQ : WB;
            LD_REQ:
                if (flush_i)
                    state_nx = IDLE;
                else if (dc_req_ready_i)
                    state_nx = LD_WAIT;
            LD_WAIT:
                if (dc_rsp_valid_i)
                    state_nx = flush_i ? IDLE : WB;
                else if (flush_i)
                    state_nx = DRAIN;
            WB:
                if (flush_i | wb_ready_i)
                    state_nx = IDLE;
            DRAIN:
                if (dc_rsp_valid_i)
                    state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    // State register plus the latched op context and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            waddr_q <= '0;
            lo_q    <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            exc_q   <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                waddr_q <= ea[DATA_W-1:2];
                lo_q    <= lo;
                size_q  <= lsu_uop.mem_size;
                uns_q   <= lsu_uop.mem_unsigned;
                exc_q   <= trap;
                tag_q   <= lsu_dst;
                data_q  <= '0;
            end else if (state == LD_WAIT && dc_rsp_valid_i && !flush_i) begin
                data_q <= ld_val;
            end
        end
    end

endmodule

// File: tb/tb_lsu_exec_unit.sv
// Directed bench for lsu_exec_unit: scoreboard of expected writebacks,
// handshake latency, flush/drain, reset and stall behaviour.
module tb_lsu_exec_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, lsu_en;
    uop_t        lsu_uop;
    logic [31:0] lsu_v1, lsu_v2;
    logic [5:0]  lsu_dst;
    logic [3:0]  lsu_sb_id;
    logic        fu_ready_o, sb_wr_valid_o;
    logic [3:0]  sb_wr_id_o, sb_wr_mask_o;
    logic [31:0] sb_wr_addr_o, sb_wr_data_o;
    logic        dc_req_valid_o, dc_req_ready_i;
    logic [31:0] dc_req_addr_o;
    logic        dc_rsp_valid_i;
    logic [31:0] dc_rsp_data_i;
    logic        wb_valid_o, wb_ready_i, wb_exc_o;
    logic [5:0]  wb_tag_o;
    logic [31:0] wb_data_o;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lsu_exec_unit dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .lsu_en(lsu_en),
        .lsu_uop(lsu_uop), .lsu_v1(lsu_v1), .lsu_v2(lsu_v2),
        .lsu_dst(lsu_dst), .lsu_sb_id(lsu_sb_id), .fu_ready_o(fu_ready_o),
        .sb_wr_valid_o(sb_wr_valid_o), .sb_wr_id_o(sb_wr_id_o),
        .sb_wr_addr_o(sb_wr_addr_o), .sb_wr_data_o(sb_wr_data_o),
        .sb_wr_mask_o(sb_wr_mask_o), .dc_req_valid_o(dc_req_valid_o),
        .dc_req_ready_i(dc_req_ready_i), .dc_req_addr_o(dc_req_addr_o),
        .dc_rsp_valid_i(dc_rsp_valid_i), .dc_rsp_data_i(dc_rsp_data_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o), .wb_exc_o(wb_exc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] v1, input logic [31:0] imm,
                         input logic [31:0] v2, input logic [5:0] dst, input logic [3:0] sb);
        lsu_en               = 1'b1;
        lsu_uop.is_load      = ld;
        lsu_uop.is_store     = st;
        lsu_uop.mem_size     = sz;
        lsu_uop.mem_unsigned = uns;
        lsu_uop.imm          = imm;
        lsu_v1               = v1;
        lsu_v2               = v2;
        lsu_dst              = dst;
        lsu_sb_id            = sb;
    endtask

    task automatic push(input logic [5:0] tag, input logic [31:0] data, input logic exc);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.exc  = exc;
        sb_q.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(wb_valid_o), 32'd1);
        chk({tag, "_sbq"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_tag"}, 32'(wb_tag_o), 32'(e.tag));
            chk({tag, "_data"}, wb_data_o, e.data);
            chk({tag, "_exc"}, 32'(wb_exc_o), 32'(e.exc));
        end
    endtask

    task automatic run_load(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [31:0] v1, input logic [31:0] imm,
                            input logic [5:0] dst, input logic [31:0] rsp,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data,
                            input int stall);
        issue(1'b1, 1'b0, sz, uns, v1, imm, 32'h0, dst, 4'h0);
        settle();
        chk({tag, "_acc"}, 32'(fu_ready_o), 32'd1);
        push(dst, exp_data, 1'b0);
        dc_req_ready_i = 1'b0;
        step();
        lsu_en = 1'b0;
        for (int i = 0; i < stall; i++) begin
            settle();
            chk({tag, "_stall_v"}, 32'(dc_req_valid_o), 32'd1);
            chk({tag, "_stall_a"}, dc_req_addr_o, exp_addr);
            step();
        end
        dc_req_ready_i = 1'b1;
        settle();
        chk({tag, "_req_v"}, 32'(dc_req_valid_o), 32'd1);
        chk({tag, "_req_a"}, dc_req_addr_o, exp_addr);
        step();
        dc_rsp_valid_i = 1'b1;
        dc_rsp_data_i  = rsp;
        settle();
        chk({tag, "_early"}, 32'(wb_valid_o), 32'd0);
        step();
        dc_rsp_valid_i = 1'b0;
        settle();
        check_wb(tag);
        step();
        settle();
        chk({tag, "_idle"}, 32'(fu_ready_o), 32'd1);
    endtask

    task automatic run_store(input string tag, input logic [1:0] sz,
                             input logic [31:0] v1, input logic [31:0] imm,
                             input logic [31:0] v2, input logic [3:0] sb,
                             input logic [5:0] dst, input logic [3:0] exp_mask,
                             input logic [31:0] exp_addr, input logic [31:0] exp_lanes);
        logic [31:0] lm;
        lm = {{8{exp_mask[3]}}, {8{exp_mask[2]}}, {8{exp_mask[1]}}, {8{exp_mask[0]}}};
        issue(1'b0, 1'b1, sz, 1'b0, v1, imm, v2, dst, sb);
        settle();
        chk({tag, "_sbv"}, 32'(sb_wr_valid_o), 32'd1);
        chk({tag, "_sbid"}, 32'(sb_wr_id_o), 32'(sb));
        chk({tag, "_sba"}, sb_wr_addr_o, exp_addr);
        chk({tag, "_sbm"}, 32'(sb_wr_mask_o), 32'(exp_mask));
        chk({tag, "_sbd"}, sb_wr_data_o & lm, exp_lanes);
        push(dst, 32'h0, 1'b0);
        step();
        lsu_en = 1'b0;
        settle();
        chk({tag, "_sb_off"}, 32'(sb_wr_valid_o), 32'd0);
        check_wb(tag);
        step();
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        lsu_en = 1'b0;
        lsu_uop = '0;
        lsu_v1 = '0;
        lsu_v2 = '0;
        lsu_dst = '0;
        lsu_sb_id = '0;
        dc_req_ready_i = 1'b1;
        dc_rsp_valid_i = 1'b0;
        dc_rsp_data_i = '0;
        wb_ready_i = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(fu_ready_o), 32'd1);
        chk("rst_sbv", 32'(sb_wr_valid_o), 32'd0);
        chk("rst_dcv", 32'(dc_req_valid_o), 32'd0);
        chk("rst_wbv", 32'(wb_valid_o), 32'd0);
        chk("rst_wbd", wb_data_o, 32'd0);
        chk("rst_exc", 32'(wb_exc_o), 32'd0);
        rst = 1'b0;
        step();

        run_load("lw", 2'd2, 1'b0, 32'h1000, 32'd4, 6'd7, 32'hDEADBEEF,
                 32'h1004, 32'hDEADBEEF, 0);
        run_load("lb", 2'd0, 1'b0, 32'h2003, 32'd0, 6'd9, 32'h80FFFF00,
                 32'h2000, 32'hFFFFFF80, 0);
        run_load("lbu", 2'd0, 1'b1, 32'h2003, 32'd0, 6'd10, 32'h80FFFF00,
                 32'h2000, 32'h00000080, 0);
        run_load("lh", 2'd1, 1'b0, 32'h5000, 32'd2, 6'd12, 32'h80017FFF,
                 32'h5000, 32'hFFFF8001, 2);
        run_load("lhu", 2'd1, 1'b1, 32'h5000, 32'd0, 6'd14, 32'h80017FFF,
                 32'h5000, 32'h00007FFF, 1);

        run_store("sh", 2'd1, 32'h3000, 32'd2, 32'h1234ABCD, 4'd5, 6'd11,
                  4'b1100, 32'h3000, 32'hABCD0000);
        run_store("sb", 2'd0, 32'h4001, 32'd0, 32'h000000A5, 4'd2, 6'd15,
                  4'b0010, 32'h4000, 32'h0000A500);
        run_store("sw", 2'd2, 32'h6000, 32'hFFFFFFFC, 32'hCAFEF00D, 4'd9, 6'd16,
                  4'hF, 32'h5FFC, 32'hCAFEF00D);
        run_store("sb_wrap", 2'd0, 32'hFFFFFFFF, 32'd1, 32'h0000007E, 4'd1, 6'd17,
                  4'b0001, 32'h0, 32'h0000007E);

`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h1002, 32'd0, 32'h0, 6'd18, 4'h0);
        settle();
        push(6'd18, 32'h0, 1'b1);
        step();
        lsu_en = 1'b0;
        settle();
        chk("mis_noreq", 32'(dc_req_valid_o), 32'd0);
        check_wb("mis");
        step();
`else
        run_load("mis", 2'd2, 1'b0, 32'h1002, 32'd0, 6'd18, 32'h11223344,
                 32'h1000, 32'h11223344, 0);
`endif

        wb_ready_i = 1'b0;
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h7000, 32'd0, 32'hFFFFFFFF, 6'd13, 4'd3);
        settle();
        chk("nop_sbv", 32'(sb_wr_valid_o), 32'd0);
        push(6'd13, 32'h0, 1'b0);
        step();
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h8000, 32'd0, 32'h55555555, 6'd33, 4'd4);
        settle();
        check_wb("hold0");
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            chk("hold_v", 32'(wb_valid_o), 32'd1);
            chk("hold_tag", 32'(wb_tag_o), 32'd13);
            chk("hold_data", wb_data_o, 32'd0);
            chk("hold_rdy", 32'(fu_ready_o), 32'd0);
            chk("hold_sbv", 32'(sb_wr_valid_o), 32'd0);
        end
        wb_ready_i = 1'b1;
        lsu_en = 1'b0;
        step();
        settle();
        chk("hold_rel_v", 32'(wb_valid_o), 32'd0);
        chk("hold_rel_rdy", 32'(fu_ready_o), 32'd1);
        step();
        settle();
        chk("hold_no_ghost", 32'(wb_valid_o), 32'd0);

        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h9000, 32'd0, 32'h0, 6'd20, 4'h0);
        step();
        lsu_en = 1'b0;
        step();
        flush_i = 1'b1;
        settle();
        chk("fw_wbv", 32'(wb_valid_o), 32'd0);
        step();
        flush_i = 1'b0;
        settle();
        chk("fw_drain_rdy0", 32'(fu_ready_o), 32'd0);
        chk("fw_drain_wbv", 32'(wb_valid_o), 32'd0);
        step();
        dc_rsp_valid_i = 1'b1;
        dc_rsp_data_i = 32'h12345678;
        settle();
        chk("fw_drain_rdy1", 32'(fu_ready_o), 32'd0);
        step();
        dc_rsp_valid_i = 1'b0;
        settle();
        chk("fw_done_rdy", 32'(fu_ready_o), 32'd1);
        chk("fw_done_wbv", 32'(wb_valid_o), 32'd0);

        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h9100, 32'd0, 32'h0, 6'd21, 4'h0);
        step();
        lsu_en = 1'b0;
        step();
        flush_i = 1'b1;
        dc_rsp_valid_i = 1'b1;
        step();
        flush_i = 1'b0;
        dc_rsp_valid_i = 1'b0;
        settle();
        chk("frsp_rdy", 32'(fu_ready_o), 32'd1);
        chk("frsp_wbv", 32'(wb_valid_o), 32'd0);

        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h9200, 32'd0, 32'h0, 6'd22, 4'h0);
        step();
        lsu_en = 1'b0;
        flush_i = 1'b1;
        settle();
        chk("freq_withdraw", 32'(dc_req_valid_o), 32'd0);
        step();
        flush_i = 1'b0;
        settle();
        chk("freq_rdy", 32'(fu_ready_o), 32'd1);
        chk("freq_dcv", 32'(dc_req_valid_o), 32'd0);

        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h9300, 32'd0, 32'h1, 6'd23, 4'd6);
        flush_i = 1'b1;
        settle();
        chk("facc_rdy", 32'(fu_ready_o), 32'd0);
        chk("facc_sbv", 32'(sb_wr_valid_o), 32'd0);
        step();
        lsu_en = 1'b0;
        flush_i = 1'b0;
        settle();
        chk("facc_wbv", 32'(wb_valid_o), 32'd0);
        chk("facc_rdy1", 32'(fu_ready_o), 32'd1);

        wb_ready_i = 1'b0;
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h9400, 32'd0, 32'h2, 6'd24, 4'd7);
        step();
        lsu_en = 1'b0;
        settle();
        chk("fwb_pre", 32'(wb_valid_o), 32'd1);
        flush_i = 1'b1;
        settle();
        chk("fwb_kill", 32'(wb_valid_o), 32'd0);
        step();
        flush_i = 1'b0;
        wb_ready_i = 1'b1;
        settle();
        chk("fwb_rdy", 32'(fu_ready_o), 32'd1);
        chk("fwb_wbv", 32'(wb_valid_o), 32'd0);

        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h9500, 32'd0, 32'h0, 6'd25, 4'h0);
        step();
        lsu_en = 1'b0;
        step();
        rst = 1'b1;
        settle();
        chk("rmid_rdy", 32'(fu_ready_o), 32'd1);
        chk("rmid_dcv", 32'(dc_req_valid_o), 32'd0);
        chk("rmid_wbv", 32'(wb_valid_o), 32'd0);
        step();
        rst = 1'b0;
        dc_rsp_valid_i = 1'b1;
        step();
        dc_rsp_valid_i = 1'b0;
        settle();
        chk("rmid_ign_wbv", 32'(wb_valid_o), 32'd0);
        chk("rmid_ign_rdy", 32'(fu_ready_o), 32'd1);

        chk("sbq_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
